segdac_ctrl: RTL

Configuration and frame-synchronous update controller for the three SEGDAC channels (R, G, B). Receives a slow 3-wire serial configuration stream from TT input pins and holds per-channel Vbias codes and channel enables in shadow registers. It commits them to the analog-facing outputs only at the start of vertical blank, and gates the 24-bit pattern-generator colour bus before thermometer decoding. It sits between the VGA pattern generator and the thermometer decoders/SEGDAC Vbias pins.

---
 rtl/segdac_ctrl_pkg.sv | 41 ++++
 rtl/segdac_ctrl_cfg_serial_rx.sv | 97 +++++++++
 rtl/segdac_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/segdac_ctrl_pkg.sv
// Purpose: shared register-map constants, register-set struct and helpers for segdac_ctrl.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package segdac_ctrl_pkg;

    // Default serial frame length: [15:12] addr, [11:8] reserved, [7:0] data.
    localparam int FRAME_BITS_DEF = 16;

    // Register addresses carried in the top nibble of a frame.
    localparam logic [3:0] ADDR_RVB  = 4'h0;
    localparam logic [3:0] ADDR_GVB  = 4'h1;
    localparam logic [3:0] ADDR_BVB  = 4'h2;
    localparam logic [3:0] ADDR_CHEN = 4'h3;
    localparam logic [3:0] ADDR_ALL  = 4'h4;
    localparam logic [3:0] ADDR_CTRL = 4'hF;

    // Bit positions inside the ctrl register data byte.
    localparam int CTRL_CLR_ERR_BIT = 0;
    localparam int CTRL_COMMIT_BIT  = 1;

    // One full register set; the same layout is used for shadow and active copies.
    typedef struct packed {
        logic [2:0] chan_en;  // bit0 R, bit1 G, bit2 B
        logic [2:0] bvb;
        logic [2:0] gvb;
        logic [2:0] rvb;
    } regs_t;

    // Move a Vbias code one LSB toward its target (used by the ramped commit).
    function automatic logic [2:0] step_toward(input logic [2:0] cur, input logic [2:0] tgt);
        logic [2:0] nxt;
        nxt = cur;
        if (cur < tgt) begin
            nxt = cur + 3'd1;
        end else if (cur > tgt) begin
            nxt = cur - 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/segdac_ctrl_cfg_serial_rx.sv
// Purpose: 3-wire serial config receiver: synchronisers, edge detect, shift register, bit counter.
// Latency: frame_valid_o/frame_bad_o pulse SYNC_STAGES+1 clk edges after cfg_csn rises at the pin.
// Backpressure: none; one result pulse per csn rise, consumer must take it that cycle.
module cfg_serial_rx #(
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_sclk_i,
    input  logic                  cfg_mosi_i,
    input  logic                  cfg_csn_i,
    output logic                  frame_valid_o,
    output logic                  frame_bad_o,
    output logic [FRAME_BITS-1:0] frame_word_o
);

    // Counter saturates one past a full frame so any excess bit reads as malformed.
    localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic                   sclk_prev_q;
    logic                   csn_prev_q;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic sclk_s, mosi_s, csn_s;
    logic sclk_rise, csn_fall, csn_rise;

    // Synchronise the asynchronous pins; reset to the idle bus state (csn high, sclk low).
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            csn_sync_q  <= '1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], cfg_sclk_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], cfg_mosi_i};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], cfg_csn_i};
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign csn_s  = csn_sync_q[SYNC_STAGES-1];

    // Previous synchronised levels for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_prev_q <= 1'b0;
            csn_prev_q  <= 1'b1;
        end else begin
            sclk_prev_q <= sclk_s;
            csn_prev_q  <= csn_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign csn_fall  = ~csn_s & csn_prev_q;
    assign csn_rise  = csn_s & ~csn_prev_q;

    // Frame start clears the collector; each sclk rise inside a frame shifts one bit in MSB-first.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (csn_fall) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (!csn_s && sclk_rise) begin
            shift_d = {shift_q[FRAME_BITS-2:0], mosi_s};
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Shift register and bit counter; reset drops any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Frame end: exactly FRAME_BITS bits is a good frame, anything else is malformed.
    assign frame_valid_o = csn_rise && (cnt_q == CNT_FULL);
    assign frame_bad_o   = csn_rise && (cnt_q != CNT_FULL);
    assign frame_word_o  = shift_q;

endmodule

// File: rtl/segdac_ctrl.sv
// Purpose: SEGDAC config shadow/active registers, vblank-synchronous commit and RGB channel gating.
// Latency: rgb_out 1 cycle; active regs update the cycle after frame_tick; writes land SYNC_STAGES+1 after csn rise.
// Backpressure: none. Optional macro SEGDAC_CTRL_RAMP_EN: commit steps Vbias codes by 1 per frame_tick.
module segdac_ctrl
    import segdac_ctrl_pkg::*;
#(
    parameter int         FRAME_BITS  = FRAME_BITS_DEF,
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] VB_RESET    = 3'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_sclk,
    input  logic        cfg_mosi,
    input  logic        cfg_csn,
    input  logic        frame_tick,
    input  logic        blank,
    input  logic [23:0] rgb_in,
    output logic [23:0] rgb_out,
    output logic [2:0]  Rvb,
    output logic [2:0]  Gvb,
    output logic [2:0]  Bvb,
    output logic        cfg_pending,
    output logic        cfg_err
);

    localparam regs_t REGS_RST = '{chan_en: 3'b111, bvb: VB_RESET, gvb: VB_RESET, rvb: VB_RESET};

    logic                  frame_valid;
    logic                  frame_bad;
    logic [FRAME_BITS-1:0] frame_word;
    logic [3:0]            wr_addr;
    logic [7:0]            wr_data;
    logic                  unused_word;

    regs_t       shadow_q, shadow_d;
    regs_t       active_q, active_d;
    logic        pending_q, pending_d;
    logic        err_q, err_d;
    logic [23:0] rgb_q, rgb_d;

    cfg_serial_rx #(
        .FRAME_BITS  (FRAME_BITS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk           (clk),
        .rst           (rst),
        .cfg_sclk_i    (cfg_sclk),
        .cfg_mosi_i    (cfg_mosi),
        .cfg_csn_i     (cfg_csn),
        .frame_valid_o (frame_valid),
        .frame_bad_o   (frame_bad),
        .frame_word_o  (frame_word)
    );

    // Reserved nibble and upper data bits carry no meaning here.
    assign wr_addr     = frame_word[FRAME_BITS-1 -: 4];
    assign wr_data     = frame_word[7:0];
    assign unused_word = ^frame_word;

    // Commit on vblank first, then apply any accepted write, so a coincident write stays pending.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        err_d     = err_q;

        if (frame_tick && pending_q) begin
`ifdef SEGDAC_CTRL_RAMP_EN
            active_d.rvb     = step_toward(active_q.rvb, shadow_q.rvb);
            active_d.gvb     = step_toward(active_q.gvb, shadow_q.gvb);
            active_d.bvb     = step_toward(active_q.bvb, shadow_q.bvb);
            active_d.chan_en = shadow_q.chan_en;
            pending_d        = (active_d != shadow_q);
`else
            active_d  = shadow_q;
            pending_d = 1'b0;
`endif
        end

        if (frame_bad) begin
            err_d = 1'b1;
        end else if (frame_valid) begin
            case (wr_addr)
                ADDR_RVB: begin
                    shadow_d.rvb = wr_data[2:0];
                    pending_d    = 1'b1;
                end
                ADDR_GVB: begin
                    shadow_d.gvb = wr_data[2:0];
                    pending_d    = 1'b1;
                end
                ADDR_BVB: begin
                    shadow_d.bvb = wr_data[2:0];
                    pending_d    = 1'b1;
                end
                ADDR_CHEN: begin
                    shadow_d.chan_en = wr_data[2:0];
                    pending_d        = 1'b1;
                end
                ADDR_ALL: begin
                    shadow_d.rvb = wr_data[2:0];
                    shadow_d.gvb = wr_data[2:0];
                    shadow_d.bvb = wr_data[2:0];
                    pending_d    = 1'b1;
                end
                ADDR_CTRL: begin
                    if (wr_data[CTRL_CLR_ERR_BIT]) begin
                        err_d = 1'b0;
                    end
                    // Immediate commit always jumps straight to the shadow values.
                    if (wr_data[CTRL_COMMIT_BIT]) begin
                        active_d  = shadow_q;
                        pending_d = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Shadow, active, pending and error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q  <= REGS_RST;
            active_q  <= REGS_RST;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    // Per-byte gating by blank and the currently active channel enables.
    always_comb begin
        rgb_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (!blank && active_q.chan_en[i]) begin
                rgb_d[8*i +: 8] = rgb_in[8*i +: 8];
            end
        end
    end

    // Registered colour output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb_out     = rgb_q;
    assign Rvb         = active_q.rvb;
    assign Gvb         = active_q.gvb;
    assign Bvb         = active_q.bvb;
    assign cfg_pending = pending_q;
    assign cfg_err     = err_q;

endmodule
